// File: rtl/shot_ctrl.sv
// rtl/shot_ctrl.sv - light-gun shot controller: trigger sync, frame-locked hit scan, shell count.
// Optional trigger debounce is enabled by defining SHOT_DEBOUNCE_EN.
module shot_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       trigger,
  input  logic [1:0] state,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] cursor_x,
  input  logic [9:0] cursor_y,
  input  logic       is_duck,
  output logic       shot,
  output logic       miss,
  output logic       flash_black,
  output logic [1:0] shells,
  output logic       out_of_ammo
);

  typedef enum logic [1:0] {IDLE, ARM, SCAN, HOLD} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic       trig_s1_q, trig_s1_d;
  logic       trig_s2_q, trig_s2_d;
  logic       trig_prev_q, trig_prev_d;
  logic       frame_d1_q, frame_d1_d;
  logic       frame_edge_q, frame_edge_d;
  logic       hit_q, hit_d;
  logic [1:0] shells_q, shells_d;
  logic       shot_q, shot_d;
  logic       miss_q, miss_d;
  logic       hold_edge_seen_q, hold_edge_seen_d;
  logic       trig_lvl;
  logic       pull;
  logic       active;
  logic       pix_hit;

`ifdef SHOT_DEBOUNCE_EN
  logic        deb_q, deb_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;

  // Level is accepted only after 65536 consecutive cycles disagreeing with the held value.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (trig_s2_q != deb_q) begin
      if (deb_cnt_q == 16'hFFFF) begin
        deb_d = trig_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign trig_lvl = deb_q;
`else
  assign trig_lvl = trig_s2_q;
`endif

  assign pull    = trig_lvl & ~trig_prev_q;
  assign active  = (state == 2'b10);
  assign pix_hit = (DrawX == cursor_x) && (DrawY == cursor_y) && is_duck;

  always_comb begin
    trig_s1_d    = trigger;
    trig_s2_d    = trig_s1_q;
    trig_prev_d  = trig_lvl;
    frame_d1_d   = frame_clk;
    frame_edge_d = frame_clk & ~frame_d1_q;
  end

  always_comb begin
    fsm_d            = fsm_q;
    shells_d         = shells_q;
    hit_d            = hit_q;
    hold_edge_seen_d = hold_edge_seen_q;
    miss_d           = 1'b0;
    if (!active) begin
      fsm_d            = IDLE;
      shells_d         = 2'd3;
      hit_d            = 1'b0;
      hold_edge_seen_d = 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (pull && (shells_q != 2'd0)) begin
            fsm_d    = ARM;
            shells_d = shells_q - 2'd1;
          end
        end
        ARM: begin
          if (frame_edge_q) begin
            fsm_d = SCAN;
            hit_d = 1'b0;
          end
        end
        SCAN: begin
          hit_d = hit_q | pix_hit;
          // A coincidence on the closing edge cycle still counts as a hit.
          if (frame_edge_q) begin
            if (hit_q | pix_hit) begin
              fsm_d            = HOLD;
              hold_edge_seen_d = 1'b0;
            end else begin
              fsm_d  = IDLE;
              miss_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_edge_q) begin
            if (hold_edge_seen_q) begin
              fsm_d = IDLE;
            end else begin
              hold_edge_seen_d = 1'b1;
            end
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
    // Registered so shot rises the cycle after HOLD entry and drops as IDLE is entered.
    shot_d = active && (fsm_q == HOLD) && (fsm_d == HOLD);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsm_q            <= IDLE;
      trig_s1_q        <= 1'b0;
      trig_s2_q        <= 1'b0;
      trig_prev_q      <= 1'b0;
      frame_d1_q       <= 1'b0;
      frame_edge_q     <= 1'b0;
      hit_q            <= 1'b0;
      shells_q         <= 2'd3;
      shot_q           <= 1'b0;
      miss_q           <= 1'b0;
      hold_edge_seen_q <= 1'b0;
    end else begin
      fsm_q            <= fsm_d;
      trig_s1_q        <= trig_s1_d;
      trig_s2_q        <= trig_s2_d;
      trig_prev_q      <= trig_prev_d;
      frame_d1_q       <= frame_d1_d;
      frame_edge_q     <= frame_edge_d;
      hit_q            <= hit_d;
      shells_q         <= shells_d;
      shot_q           <= shot_d;
      miss_q           <= miss_d;
      hold_edge_seen_q <= hold_edge_seen_d;
    end
  end

  assign shot        = shot_q;
  assign miss        = miss_q;
  assign flash_black = (fsm_q == ARM) || (fsm_q == SCAN);
  assign shells      = shells_q;
  assign out_of_ammo = (shells_q == 2'd0);

endmodule

// File: tb/tb_shot_ctrl.sv
// tb/tb_shot_ctrl.sv - randomized scoreboard bench for shot_ctrl.
module tb_shot_ctrl;

  localparam int P = 32;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       trigger;
  logic [1:0] state;
  logic [9:0] DrawX, DrawY, cursor_x, cursor_y;
  logic       is_duck;
  logic       shot, miss, flash_black, out_of_ammo;
  logic [1:0] shells;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_shells;
  bit exp_q[$];
  bit hold_abort = 1'b0;

  shot_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trigger(trigger), .state(state),
    .DrawX(DrawX), .DrawY(DrawY), .cursor_x(cursor_x), .cursor_y(cursor_y), .is_duck(is_duck),
    .shot(shot), .miss(miss), .flash_black(flash_black), .shells(shells), .out_of_ammo(out_of_ammo)
  );

  always #5 Clk = ~Clk;

  initial begin
    frame_clk = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      frame_clk = (cyc % P) < (P / 2);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_phase(input int ph);
    bit found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      @(posedge Clk);
      #2;
      if ((cyc % P) == ph) found = 1'b1;
    end
    if (!found) check("phase_reached", 0, 1);
  endtask

  task automatic pull_trigger();
    trigger = 1'b1;
    repeat (6) @(posedge Clk);
    #2;
    trigger = 1'b0;
  endtask

  task automatic reload();
    state = 2'b01;
    repeat (3) @(posedge Clk);
    #2;
    state = 2'b10;
    model_shells = 3;
  endtask

  task automatic episode(input bit active, input logic [9:0] cx, input logic [9:0] cy,
                         input logic [9:0] dx, input logic [9:0] dy, input bit duck, input bit second);
    bit accepted;
    bit exp_hit;
    cursor_x = cx; cursor_y = cy; DrawX = dx; DrawY = dy; is_duck = duck;
    if (!active) begin
      state = 2'b01;
      repeat (3) @(posedge Clk);
      #2;
      model_shells = 3;
    end
    exp_hit = duck && (cx == dx) && (cy == dy);
    wait_phase($urandom_range(4, 12));
    accepted = active && (model_shells > 0);
    if (accepted) begin
      exp_q.push_back(exp_hit);
      model_shells--;
    end
    pull_trigger();
    check("flash_armed", flash_black, accepted);
    check("shells_after_pull", shells, model_shells);
    check("out_of_ammo", out_of_ammo, model_shells == 0);
    if (second) begin
      wait_phase(0);
      wait_phase(16);
      pull_trigger();
      check("flash_scan", flash_black, accepted);
      check("shells_second_pull", shells, model_shells);
    end
    repeat (5 * P) @(posedge Clk);
    #2;
    check("flash_done", flash_black, 0);
    check("shells_done", shells, model_shells);
    check("queue_drained", exp_q.size(), 0);
    state = 2'b10;
    @(posedge Clk);
    #2;
  endtask

  // Monitor: outcomes are popped as the DUT presents miss pulses or shot rises.
  initial begin
    bit prev_shot = 1'b0;
    bit prev_miss = 1'b0;
    bit prev_frame = 1'b0;
    int shot_frames = 0;
    bit e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_shot = 1'b0;
        prev_miss = 1'b0;
      end else begin
        check("shot_miss_exclusive", shot & miss, 0);
        check("ooa_tracks_shells", out_of_ammo, shells == 2'd0);
        if (miss) begin
          if (prev_miss) check("miss_one_cycle", 0, 1);
          else begin
            check("miss_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("miss_outcome_hit", 0, e);
            end
          end
        end
        if (shot && !prev_shot) begin
          shot_frames = 0;
          check("shot_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("shot_outcome_hit", 1, e);
          end
        end
        if (shot && frame_clk && !prev_frame) shot_frames++;
        if (!shot && prev_shot && !hold_abort) check("shot_frame_span", shot_frames, 2);
        prev_shot = shot;
        prev_miss = miss;
      end
      prev_frame = frame_clk;
    end
  end

  initial begin
    logic [9:0] rx, ry, dx, dy;
    bit found;
    int mode;
    Reset = 1'b1; trigger = 1'b0; state = 2'b10;
    DrawX = '0; DrawY = '0; cursor_x = '0; cursor_y = '0; is_duck = 1'b0;
    model_shells = 3;
    #1;
    check("rst_shot", shot, 0);
    check("rst_miss", miss, 0);
    check("rst_flash", flash_black, 0);
    check("rst_shells", shells, 3);
    check("rst_ooa", out_of_ammo, 0);
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b0;

    episode(1, 10'd200, 10'd150, 10'd200, 10'd150, 1, 0);
    episode(1, 10'd50, 10'd50, 10'd200, 10'd150, 1, 0);
    reload();
    for (int i = 0; i < 4; i++) episode(1, 10'd50, 10'd50, 10'd200, 10'd150, 1, 0);
    check("ooa_after_four", out_of_ammo, 1);
    reload();
    episode(1, 10'd300, 10'd100, 10'd300, 10'd100, 1, 1);
    episode(1, 10'd300, 10'd100, 10'd301, 10'd100, 1, 1);

    for (int i = 0; i < 30; i++) begin
      rx = 10'($urandom); ry = 10'($urandom);
      mode = $urandom_range(0, 2);
      dx = rx; dy = ry;
      if (mode == 1) begin
        if ($urandom_range(0, 1) == 0) dx = rx ^ 10'($urandom_range(1, 1023));
        else dy = ry ^ 10'($urandom_range(1, 1023));
      end
      episode($urandom_range(0, 5) != 0, rx, ry, dx, dy, mode != 2, 1'($urandom_range(0, 1)));
    end

    // Round ends while the hit is being held.
    reload();
    cursor_x = 10'd200; cursor_y = 10'd150; DrawX = 10'd200; DrawY = 10'd150; is_duck = 1'b1;
    wait_phase(6);
    exp_q.push_back(1'b1);
    model_shells--;
    pull_trigger();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge Clk);
      #2;
      if (shot) found = 1'b1;
    end
    check("hold_shot_seen", found, 1);
    hold_abort = 1'b1;
    state = 2'b01;
    @(posedge Clk);
    #2;
    check("abort_shot", shot, 0);
    check("abort_flash", flash_black, 0);
    check("abort_shells", shells, 3);
    model_shells = 3;
    repeat (4) @(posedge Clk);
    #2;
    hold_abort = 1'b0;
    state = 2'b10;
    check("abort_queue", exp_q.size(), 0);

    // Asynchronous reset in the middle of SCAN.
    is_duck = 1'b0;
    wait_phase(6);
    pull_trigger();
    wait_phase(0);
    wait_phase(10);
    check("scan_flash", flash_black, 1);
    check("scan_shells", shells, 2);
    Reset = 1'b1;
    #1;
    check("async_rst_flash", flash_black, 0);
    check("async_rst_shot", shot, 0);
    check("async_rst_miss", miss, 0);
    check("async_rst_shells", shells, 3);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    model_shells = 3;
    repeat (5 * P) @(posedge Clk);
    #2;
    check("post_rst_flash", flash_black, 0);
    check("post_rst_shells", shells, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_ctrl.md
SHOT_CTRL -- requirements
Module: shot_ctrl

Interface
REQ-001 Clk  input  1  system clock, 50 MHz; sole clock domain.
REQ-002 Reset  input  1  reset, asynchronous, active-high.
REQ-003 frame_clk  input  1  frame strobe (~60 Hz); block-internal rising-edge detect: one delay register, one registered edge flag.
REQ-004 trigger  input  1  raw gun button, active-high, asynchronous to Clk.
REQ-005 state  input  2  game state; 2'b10 = round active.
REQ-006 DrawX, DrawY  input  10 each  current pixel coordinates.
REQ-007 cursor_x, cursor_y  input  10 each  crosshair pixel coordinates.
REQ-008 is_duck  input  1  current pixel belongs to duck sprite (from duck mover).
REQ-009 shot  output  1  hit level to duck mover.
REQ-010 miss  output  1  one-Clk pulse, trigger resolved without hit.
REQ-011 flash_black  output  1  video mask request: blank background while hit test runs.
REQ-012 shells  output  2  shells remaining, 0..3.
REQ-013 out_of_ammo  output  1  high when shells == 0.

Function
REQ-014 trigger SHALL pass a 2-FF synchronizer; a rising edge of the synchronized signal is a "pull".
REQ-015 FSM states: IDLE, ARM, SCAN, HOLD; frame edge = registered frame_clk rising-edge flag.
REQ-016 IDLE -> ARM on a pull while state == 2'b10 and shells > 0; shells decrements by 1 in the same cycle.
REQ-017 Pulls in ARM/SCAN/HOLD, with shells == 0, or with state != 2'b10 SHALL be ignored; shells unchanged.
REQ-018 ARM -> SCAN on next frame edge; hit flag cleared on entry to SCAN.
REQ-019 In SCAN, hit flag SHALL set on any Clk where DrawX == cursor_x, DrawY == cursor_y and is_duck == 1; sticky until SCAN exit.
REQ-020 SCAN exit on next frame edge: hit -> HOLD; no hit -> IDLE with miss = 1 for exactly that one cycle.
REQ-021 HOLD: shot = 1 from the cycle after entry until the second subsequent frame edge inclusive, then -> IDLE with shot = 0 next cycle (spans one full frame edge regardless of consumer edge-detect latency).
REQ-022 flash_black = 1 exactly while FSM in ARM or SCAN.
REQ-023 shot and miss SHALL never be high in the same cycle; shot = 0 outside HOLD.
REQ-024 When state != 2'b10: FSM forced to IDLE next cycle, shot/miss/flash_black = 0, shells reloads to 3, hit flag cleared; applies mid-operation.
REQ-025 shells SHALL never wrap below 0; out_of_ammo combinational from shells.
REQ-026 Pull coincident with frame edge in IDLE: accepted, ARM waits for the following frame edge.

Reset
REQ-027 On Reset: FSM = IDLE, shells = 3, shot = 0, miss = 0, flash_black = 0, hit flag = 0, synchronizer and frame-edge registers = 0.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no further shot/miss pulse.

Configuration
REQ-029 Macro SHOT_DEBOUNCE_EN defined: synchronized trigger SHALL be stable for 65536 consecutive Clk cycles before its level is accepted; pulls derived from the debounced level.
REQ-030 SHOT_DEBOUNCE_EN undefined: pulls derived directly from synchronized trigger; no debounce counter instantiated.

Verification
REQ-031 state=2'b10, duck covers (200,150), cursor=(200,150), one pull -> flash_black through one frame, then shot high across next two frame edges, shells 3->2, miss never high.
REQ-032 Same, cursor=(50,50) off duck -> miss one-cycle pulse at SCAN-end frame edge, shot stays 0, shells 3->2.
REQ-033 Four hit-less pulls, each resolved -> shells 3,2,1,0; fourth pull ignored, out_of_ammo = 1, no ARM entry.
REQ-034 Second pull during SCAN -> ignored, shells decremented once only.
REQ-035 state changes 2'b10 -> 2'b01 during HOLD -> shot = 0 next cycle, FSM IDLE, shells = 3.
REQ-036 Reset pulse asserted mid-SCAN asynchronously -> all outputs at reset values with no Clk edge required; with SHOT_DEBOUNCE_EN, 1000-cycle trigger glitch -> no pull.
